// File: rtl/l1_dcache_pkg.sv
// Shared types and helpers for the L1 data cache: FSM encodings, geometry
// derivations and the store byte-merge.
package l1_dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_RESUME
  } cache_state_e;

  function automatic int line_bits(input int offset_bits);
    return 8 << offset_bits;
  endfunction

  function automatic int tag_bits(input int addr_w, input int index_bits, input int offset_bits);
    return addr_w - index_bits - offset_bits;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++)
      merged[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Line storage for the direct-mapped cache: valid/dirty flags (reset), tag and
// data (not reset), combinational read, byte-enabled word write and line fill.
module l1_dcache_array
  import l1_dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 22,
  parameter int WORDS      = 4,
  parameter int WSEL_BITS  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [INDEX_BITS-1:0]      idx_i,
  output logic                       valid_o,
  output logic                       dirty_o,
  output logic [TAG_BITS-1:0]        tag_o,
  output logic [WORDS-1:0][31:0]     line_o,
  input  logic                       wr_en_i,
  input  logic [WSEL_BITS-1:0]       wsel_i,
  input  logic [3:0]                 be_i,
  input  logic [31:0]                wdata_i,
  input  logic                       fill_en_i,
  input  logic [TAG_BITS-1:0]        fill_tag_i,
  input  logic [WORDS-1:0][31:0]     fill_data_i,
  input  logic                       clr_dirty_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]          valid_q;
  logic [LINES-1:0]          dirty_q;
  logic [TAG_BITS-1:0]       tag_q  [LINES];
  logic [WORDS-1:0][31:0]    data_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clock) begin
    if (fill_en_i) begin
      data_q[idx_i] <= fill_data_i;
      tag_q[idx_i]  <= fill_tag_i;
    end else if (wr_en_i) begin
      data_q[idx_i][wsel_i] <= byte_merge(data_q[idx_i][wsel_i], wdata_i, be_i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end else if (wr_en_i) begin
        dirty_q[idx_i] <= 1'b1;
      end else if (clr_dirty_i) begin
        dirty_q[idx_i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 data cache: zero-wait hits,
// stall-and-refill miss FSM over a line-wide req/ack port, saturating counters.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpu_rd_i,
  input  logic                         cpu_wr_i,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr_i,
  input  logic [31:0]                  cpu_wdata_i,
  input  logic [3:0]                   cpu_be_i,
  output logic [31:0]                  cpu_rdata_o,
  output logic                         cpu_stall_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [(8<<OFFSET_BITS)-1:0]  mem_wdata_o,
  input  logic [(8<<OFFSET_BITS)-1:0]  mem_rdata_i,
  input  logic                         mem_ack_i,
  output logic [31:0]                  hit_count_o,
  output logic [31:0]                  miss_count_o
);

  localparam int LINE_BITS = line_bits(OFFSET_BITS);
  localparam int TAG_BITS  = tag_bits(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS);
  localparam int WORDS     = LINE_BITS / 32;
  localparam int WSEL_BITS = OFFSET_BITS - 2;

  cache_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]    mem_wdata_q, mem_wdata_d;
  logic [31:0]             hit_q, miss_q;

  logic                    req, hit, stall;
  logic                    hit_inc, miss_inc;
  logic                    wr_en, fill_en, clr_dirty;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]     tag;
  logic [WSEL_BITS-1:0]    wsel;
  logic                    addr_lsb_unused;

  logic                    arr_valid, arr_dirty;
  logic [TAG_BITS-1:0]     arr_tag;
  logic [WORDS-1:0][31:0]  arr_line;

  // Outside IDLE the CPU holds its request, but the captured copy drives the miss sequence.
  assign addr_sel        = (state_q == S_IDLE) ? cpu_addr_i : req_addr_q;
  assign idx             = addr_sel[OFFSET_BITS +: INDEX_BITS];
  assign tag             = addr_sel[ADDR_WIDTH-1 -: TAG_BITS];
  assign wsel            = addr_sel[2 +: WSEL_BITS];
  assign addr_lsb_unused = ^addr_sel[1:0];

  assign req = cpu_rd_i | cpu_wr_i;
  assign hit = arr_valid && (arr_tag == tag);

  l1_dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .WORDS      (WORDS),
    .WSEL_BITS  (WSEL_BITS)
  ) u_array (
    .clock       (clock),
    .reset       (reset),
    .idx_i       (idx),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .tag_o       (arr_tag),
    .line_o      (arr_line),
    .wr_en_i     (wr_en & ~reset),
    .wsel_i      (wsel),
    .be_i        (cpu_be_i),
    .wdata_i     (cpu_wdata_i),
    .fill_en_i   (fill_en & ~reset),
    .fill_tag_i  (tag),
    .fill_data_i (mem_rdata_i),
    .clr_dirty_i (clr_dirty & ~reset)
  );

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;
    cpu_rdata_o = '0;
    wr_en       = 1'b0;
    fill_en     = 1'b0;
    clr_dirty   = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          hit_inc = 1'b1;
          if (cpu_wr_i) wr_en = 1'b1;
          else          cpu_rdata_o = arr_line[wsel];
        end else if (req) begin
          stall      = 1'b1;
          miss_inc   = 1'b1;
          req_addr_d = cpu_addr_i;
          mem_req_d  = 1'b1;
          if (arr_valid && arr_dirty) begin
            state_d     = S_WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {arr_tag, idx, {OFFSET_BITS{1'b0}}};
            mem_wdata_d = arr_line;
          end else begin
            state_d    = S_ALLOCATE;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, {OFFSET_BITS{1'b0}}};
          end
        end
      end
      S_WRITEBACK: begin
        stall = 1'b1;
        if (mem_ack_i) begin
          clr_dirty = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        stall = 1'b1;
        // After a write-back the request is low for one cycle; acks there are stray.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag, idx, {OFFSET_BITS{1'b0}}};
        end else if (mem_ack_i) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_RESUME;
        end
      end
      S_RESUME: begin
        stall   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (hit_inc && hit_q != '1)   hit_q  <= hit_q + 32'd1;
      if (miss_inc && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end

  assign cpu_stall_o  = stall & ~reset;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: cold miss, hits, byte store, dirty eviction,
// delayed refill ack and reset in the middle of a write-back.
module tb_l1_dcache;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]    cpu_be;
  logic          cpu_stall, mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr, hit_count, miss_count;
  logic [127:0]  mem_wdata, mem_rdata;

  int            n_asrt = 0;
  int            n_fail = 0;
  int            wb_cnt = 0;
  logic [31:0]   wb_addr;
  logic [127:0]  wb_data;
  int            st;

  localparam logic [127:0] FILL1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] FILL2 = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] FILL3 = 128'h44444444_33333333_22222222_11111111;

  l1_dcache dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_rd_i     (cpu_rd),
    .cpu_wr_i     (cpu_wr),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_be_i     (cpu_be),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_stall_o  (cpu_stall),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    cyc();
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
    #1;
  endtask

  // Memory responder: acks write-backs at once, refills after dly waiting cycles.
  // Entered at the sample point of the miss cycle; returns at the first unstalled one.
  task automatic serve(input logic [127:0] fill, input int dly, input logic [31:0] exp_fill,
                       output int stalls);
    int waited;
    bit drop_chk;
    stalls = 0; waited = 0; drop_chk = 0;
    for (int g = 0; g < 64 && cpu_stall === 1'b1; g++) begin
      stalls++;
      if (drop_chk) check("req_drop_after_ack", mem_req, 1'b0);
      drop_chk = 0;
      if (mem_req === 1'b1) begin
        if (mem_we === 1'b1) begin
          wb_addr = mem_addr; wb_data = mem_wdata; wb_cnt++;
          mem_ack = 1'b1; drop_chk = 1;
        end else begin
          check("fill_addr_held", mem_addr, exp_fill);
          if (waited >= dly) begin
            mem_rdata = fill; mem_ack = 1'b1; drop_chk = 1; waited = 0;
          end else begin
            waited++;
          end
        end
      end
      cyc();
      mem_ack = 1'b0;
      #1;
    end
    if (cpu_stall !== 1'b0) check("serve_timeout_stall", cpu_stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    reset = 1'b0;

    // Cold load miss: 3 stall cycles, refill from 0x100
    step(1, 0, 32'h100, 0, 0);
    check("t1_miss_stall_comb", cpu_stall, 1'b1);
    check("t1_req_not_yet", mem_req, 1'b0);
    serve(FILL1, 0, 32'h100, st);
    check("t1_stall_cycles", st, 3);
    check("t1_rdata", cpu_rdata, 32'h1);
    check("t1_miss_count", miss_count, 1);
    check("t1_no_writeback", wb_cnt, 0);

    // Back-to-back hits
    step(1, 0, 32'h104, 0, 0);
    check("t2_hit_count_a", hit_count, 1);
    check("t2_stall_a", cpu_stall, 1'b0);
    check("t2_rdata_104", cpu_rdata, 32'h2);
    step(1, 0, 32'h10C, 0, 0);
    check("t2_rdata_10c", cpu_rdata, 32'h4);

    // Store with rd and wr both high acts as a store; low half-word only
    step(1, 1, 32'h108, 32'hDEADBEEF, 4'b0011);
    check("t3_hit_count", hit_count, 3);
    check("t3_store_stall", cpu_stall, 1'b0);
    check("t3_store_rdata_zero", cpu_rdata, 32'h0);
    step(1, 0, 32'h108, 0, 0);
    check("t3_merged_rdata", cpu_rdata, 32'h0000BEEF);
    check("t3_load_stall", cpu_stall, 1'b0);

    // Conflict miss on dirty line: write-back of merged line, then refill, 5 stalls
    step(1, 0, 32'h500, 0, 0);
    check("t4_hit_count", hit_count, 5);
    check("t4_miss_stall_comb", cpu_stall, 1'b1);
    serve(FILL2, 0, 32'h500, st);
    check("t4_stall_cycles", st, 5);
    check("t4_wb_cnt", wb_cnt, 1);
    check("t4_wb_addr", wb_addr, 32'h100);
    check("t4_wb_data", wb_data, 128'h00000004_0000BEEF_00000002_00000001);
    check("t4_rdata", cpu_rdata, 32'hA);
    check("t4_miss_count", miss_count, 2);

    // Clean miss with refill ack held off for 7 cycles
    step(1, 0, 32'h904, 0, 0);
    check("t5_hit_count", hit_count, 6);
    check("t5_miss_stall_comb", cpu_stall, 1'b1);
    serve(FILL3, 7, 32'h900, st);
    check("t5_stall_cycles", st, 10);
    check("t5_wb_cnt", wb_cnt, 1);
    check("t5_rdata", cpu_rdata, 32'h22222222);
    check("t5_miss_count", miss_count, 3);

    // Dirty the line, miss on it, then reset while the write-back is pending
    step(0, 1, 32'h908, 32'hCAFEF00D, 4'b1111);
    check("t6_store_stall", cpu_stall, 1'b0);
    step(1, 0, 32'h100, 0, 0);
    check("t6_hit_count", hit_count, 8);
    check("t6_miss_stall_comb", cpu_stall, 1'b1);
    step(1, 0, 32'h100, 0, 0);
    check("t6_wb_req", mem_req, 1'b1);
    check("t6_wb_we", mem_we, 1'b1);
    check("t6_wb_addr", mem_addr, 32'h900);
    check("t6_miss_count", miss_count, 4);
    reset = 1'b1; mem_ack = 1'b1;
    #1;
    check("t6_rst_req", mem_req, 1'b0);
    check("t6_rst_stall", cpu_stall, 1'b0);
    check("t6_rst_miss_count", miss_count, 0);
    check("t6_rst_hit_count", hit_count, 0);
    cyc();
    mem_ack = 1'b0; reset = 1'b0;
    #1;
    check("t6_post_rst_miss", cpu_stall, 1'b1);
    check("t6_post_rst_req", mem_req, 1'b0);
    serve(FILL1, 0, 32'h100, st);
    check("t6_stall_cycles", st, 3);
    check("t6_no_writeback", wb_cnt, 1);
    check("t6_rdata", cpu_rdata, 32'h1);
    check("t6_miss_count_after", miss_count, 1);
    step(0, 0, 32'h0, 0, 0);
    check("t6_hit_count_after", hit_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
